// File: rtl/prio_rr_arbiter.sv
// Four-way arbiter with fixed or round-robin priority (3 highest at reset), registered one-hot grant, 1-cycle req->gnt.
// No backpressure: a grant is held while its owner requests, until MAX_HOLD forces re-arbitration.
module prio_rr_arbiter #(
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       hold_expired
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic [1:0] last_id_q;
    logic       gnt_valid_q;
    logic       hold_expired_q;
    logic [7:0] cnt_q;

    logic       own_req;
    logic       at_limit;
    logic [3:0] masked;
    logic [3:0] cand;
    logic       win_vld;
    logic [1:0] win_id;
    logic [1:0] rr_idx;

    // On expiry the owner is masked out, but falls back in if nobody else wants the resource.
    always_comb begin
        own_req  = req[gnt_id_q];
        at_limit = HOLD_EN && (cnt_q >= HOLD_LIM);
        masked   = req & ~(4'b0001 << gnt_id_q);
        cand     = req;
        if (state_q == OWN && own_req && at_limit && masked != 4'b0000) begin
            cand = masked;
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        rr_idx  = 2'd0;
        if (MODE == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (cand[i]) begin
                    win_vld = 1'b1;
                    win_id  = 2'(i);
                end
            end
        end else begin
            // Walk from lowest to highest priority so the last hit is the winner.
            for (int i = 4; i >= 1; i--) begin
                rr_idx = last_id_q - 2'(i);
                if (cand[rr_idx]) begin
                    win_vld = 1'b1;
                    win_id  = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gnt_q          <= 4'b0000;
            gnt_id_q       <= 2'd0;
            gnt_valid_q    <= 1'b0;
            hold_expired_q <= 1'b0;
            cnt_q          <= 8'd0;
            last_id_q      <= 2'd0;
        end else begin
            hold_expired_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q     <= OWN;
                        gnt_q       <= 4'b0001 << win_id;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= 8'd1;
                        last_id_q   <= win_id;
                    end
                end
                OWN: begin
                    if (own_req && !at_limit) begin
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end else if (win_vld) begin
                        // Release with others pending, or forced expiry: hand over at this edge.
                        hold_expired_q <= own_req;
                        gnt_q          <= 4'b0001 << win_id;
                        gnt_id_q       <= win_id;
                        gnt_valid_q    <= 1'b1;
                        cnt_q          <= 8'd1;
                        last_id_q      <= win_id;
                    end else begin
                        state_q     <= IDLE;
                        gnt_q       <= 4'b0000;
                        gnt_id_q    <= 2'd0;
                        gnt_valid_q <= 1'b0;
                        cnt_q       <= 8'd0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= 4'b0000;
                    gnt_id_q    <= 2'd0;
                    gnt_valid_q <= 1'b0;
                    cnt_q       <= 8'd0;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign gnt_valid    = gnt_valid_q;
    assign hold_expired = hold_expired_q;

endmodule
